// File: rtl/line_feeder.sv
// Frame buffer feeding the 5x5 lane-permutation controller: captures one frame
// of lines from a valid/ready stream, reports its size, then serves lines on request.
module line_feeder #(
  parameter int MEMSIZE = 25,
  parameter int DEPTH   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [MEMSIZE-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               readLine,
  output logic [MEMSIZE-1:0] line,
  output logic               line_valid,
  output logic [5:0]         count,
  output logic               frame_ready,
  input  logic               ctrl_ready,
  output logic               busy,
  output logic               overflow,
  output logic               underrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    HANDOFF = 2'd2,
    SERVE   = 2'd3
  } state_t;

  state_t             state_reg;
  logic [5:0]         wr_ptr_reg;
  logic [5:0]         rd_ptr_reg;
  logic [MEMSIZE-1:0] mem [DEPTH];
  logic               accept;

  // in_ready is a registered copy of "state is FILL", so a beat is taken only in FILL.
  assign accept = in_valid & in_ready;

  // Buffer has no reset: stale lines are harmless because rd_ptr never passes count.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      in_ready    <= 1'b0;
      line        <= '0;
      line_valid  <= 1'b0;
      count       <= '0;
      frame_ready <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_ready <= 1'b0;
      line_valid  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            underrun   <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            state_reg  <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + 6'd1;
            if (in_last) begin
              in_ready  <= 1'b0;
              state_reg <= HANDOFF;
            end else if (wr_ptr_reg == LAST_IDX) begin
              // Buffer full without in_last: truncate and hand off what we have.
              overflow  <= 1'b1;
              in_ready  <= 1'b0;
              state_reg <= HANDOFF;
            end
          end
        end
        HANDOFF: begin
          count       <= wr_ptr_reg;
          frame_ready <= 1'b1;
          state_reg   <= SERVE;
        end
        SERVE: begin
          if (readLine) begin
            if (rd_ptr_reg < count) begin
              line       <= mem[rd_ptr_reg[AW-1:0]];
              rd_ptr_reg <= rd_ptr_reg + 6'd1;
              line_valid <= 1'b1;
            end else begin
              underrun <= 1'b1;
            end
          end
          // A read in the same cycle still completes; its pulse lands in IDLE.
          if (ctrl_ready) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_feeder.sv
// Directed bench for line_feeder: reset, fill/serve, overflow, underrun,
// handoff back to IDLE and ignored control inputs.
module tb_line_feeder;

  localparam int MEMSIZE = 25;
  localparam int DEPTH   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic [MEMSIZE-1:0] in_data;
  logic               in_last;
  logic               in_ready;
  logic               readLine;
  logic [MEMSIZE-1:0] line;
  logic               line_valid;
  logic [5:0]         count;
  logic               frame_ready;
  logic               ctrl_ready;
  logic               busy;
  logic               overflow;
  logic               underrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_feeder #(.MEMSIZE(MEMSIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .readLine(readLine), .line(line), .line_valid(line_valid),
    .count(count), .frame_ready(frame_ready), .ctrl_ready(ctrl_ready),
    .busy(busy), .overflow(overflow), .underrun(underrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [MEMSIZE-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [MEMSIZE-1:0] exp);
    readLine = 1'b1;
    tick();
    readLine = 1'b0;
    chk({tag, "_line"}, 32'(line), 32'(exp));
    chk({tag, "_valid"}, 32'(line_valid), 32'd1);
  endtask

  task automatic finish_frame;
    ctrl_ready = 1'b1;
    tick();
    ctrl_ready = 1'b0;
  endtask

  initial begin
    int acc;
    bit seen;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    readLine = 1'b0; ctrl_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_line_valid", 32'(line_valid), 32'd0);
    chk("rst_flags", 32'({frame_ready, overflow, underrun}), 32'd0);

    // Reset in the middle of FILL
    do_start();
    chk("fill_in_ready", 32'(in_ready), 32'd1);
    chk("fill_busy", 32'(busy), 32'd1);
    push(25'h0A, 1'b0); push(25'h0B, 1'b0); push(25'h0C, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_line", 32'(line), 32'd0);

    // Five-line frame, frame_ready N+1 cycles after first beat
    do_start();
    for (int i = 1; i <= 5; i++) push(MEMSIZE'(i), i == 5);
    chk("f5_fr_early", 32'(frame_ready), 32'd0);
    chk("f5_in_ready_off", 32'(in_ready), 32'd0);
    tick();
    chk("f5_frame_ready", 32'(frame_ready), 32'd1);
    chk("f5_count", 32'(count), 32'd5);
    tick();
    chk("f5_fr_pulse_end", 32'(frame_ready), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      read_one($sformatf("f5_rd%0d", i), MEMSIZE'(i));
      tick();
      chk($sformatf("f5_rd%0d_drop", i), 32'(line_valid), 32'd0);
    end
    chk("f5_flags", 32'({overflow, underrun}), 32'd0);
    finish_frame();
    chk("f5_idle_busy", 32'(busy), 32'd0);
    chk("f5_idle_count_hold", 32'(count), 32'd5);
    chk("f5_idle_line_hold", 32'(line), 32'd5);

    // readLine in IDLE is ignored
    readLine = 1'b1;
    tick();
    readLine = 1'b0;
    chk("idle_rd_underrun", 32'(underrun), 32'd0);
    chk("idle_rd_valid", 32'(line_valid), 32'd0);

    // 40 beats without in_last: truncated at DEPTH
    do_start();
    acc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1;
      in_data  = MEMSIZE'(32'h100 + i);
      in_last  = 1'b0;
      if (in_ready) acc++;
      tick();
      if (acc == DEPTH && !seen) begin
        seen = 1'b1;
        chk("ovf_in_ready_after_32", 32'(in_ready), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("ovf_accepted", 32'(acc), 32'(DEPTH));
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) read_one($sformatf("ovf_rd%0d", i), MEMSIZE'(32'h100 + i));
    readLine = 1'b1;
    tick();
    readLine = 1'b0;
    chk("ovf_underrun", 32'(underrun), 32'd1);
    finish_frame();

    // Exactly DEPTH lines ending with in_last: no overflow
    do_start();
    for (int i = 0; i < DEPTH; i++) push(MEMSIZE'(32'h200 + i), i == DEPTH - 1);
    tick();
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_overflow", 32'(overflow), 32'd0);
    chk("full_frame_ready", 32'(frame_ready), 32'd1);
    finish_frame();

    // Three-line frame, fourth read underruns
    do_start();
    push(25'hAAA, 1'b0); push(25'hBBB, 1'b0); push(25'hCCC, 1'b1);
    tick();
    chk("f3_count", 32'(count), 32'd3);
    read_one("f3_rd1", 25'hAAA);
    read_one("f3_rd2", 25'hBBB);
    read_one("f3_rd3", 25'hCCC);
    readLine = 1'b1;
    tick();
    readLine = 1'b0;
    chk("f3_underrun", 32'(underrun), 32'd1);
    chk("f3_line_hold", 32'(line), 32'hCCC);
    chk("f3_valid_low", 32'(line_valid), 32'd0);

    // start in SERVE is ignored
    start = 1'b1;
    in_valid = 1'b1; in_data = 25'h1234;
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    chk("serve_start_busy", 32'(busy), 32'd1);
    chk("serve_start_in_ready", 32'(in_ready), 32'd0);
    chk("serve_start_count", 32'(count), 32'd3);
    chk("serve_start_underrun", 32'(underrun), 32'd1);
    finish_frame();
    chk("f3_idle_busy", 32'(busy), 32'd0);

    // in_valid in IDLE and in the start cycle is not accepted
    in_valid = 1'b1; in_data = 25'hDEAD;
    tick();
    chk("idle_beat_in_ready", 32'(in_ready), 32'd0);
    chk("idle_beat_busy", 32'(busy), 32'd0);
    in_data = 25'h777; in_last = 1'b1;
    do_start();
    in_valid = 1'b0; in_last = 1'b0;
    chk("f2_in_ready", 32'(in_ready), 32'd1);
    push(25'h11, 1'b0); push(25'h22, 1'b1);
    tick();
    chk("f2_count", 32'(count), 32'd2);
    chk("f2_flags_cleared", 32'({overflow, underrun}), 32'd0);
    read_one("f2_rd1", 25'h11);
    // Read and ctrl_ready together: read completes, then IDLE
    readLine = 1'b1; ctrl_ready = 1'b1;
    tick();
    readLine = 1'b0; ctrl_ready = 1'b0;
    chk("f2_rd2_line", 32'(line), 32'h22);
    chk("f2_done_busy", 32'(busy), 32'd0);
    tick();
    chk("f2_idle_valid", 32'(line_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
